// File: rtl/jk_share_arbiter.sv
// jk_share_arbiter: round-robin arbiter sharing one JK storage bit among NUM_REQ requesters.
// Define JK_ARB_LOCK_EN to add a lock input that lets the current owner keep the grant.
module jk_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] jk,
`ifdef JK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock,
`endif
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 q,
    output logic                 q_changed,
    output logic [CNT_W-1:0]     cmd_cnt,
    output logic                 busy
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_nxt_ptr;
    logic [1:0]         w_cmd;
    logic               w_nxt_q;
    logic               w_hold;
    logic               w_any;
    logic [NUM_REQ-1:0] w_oh;
`ifdef JK_ARB_LOCK_EN
    logic [PTR_W-1:0]   r_last;
`endif
    assign w_any = |req;
    // Scan from the far end back toward ptr so the closest requester is the last one written.
    always_comb begin
        w_win  = '0;
        w_idx  = '0;
        w_hold = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (req[w_idx]) w_win = w_idx;
        end
`ifdef JK_ARB_LOCK_EN
        w_hold = |(gnt & lock & req);
        if (w_hold) w_win = r_last;
`endif
        w_cmd     = 2'(jk >> {w_win, 1'b0});
        w_nxt_q   = w_cmd == 2'b11 ? ~q : w_cmd == 2'b10 ? 1'b1 : w_cmd == 2'b01 ? 1'b0 : q;
        w_nxt_ptr = w_hold ? r_ptr : PTR_W'((int'(w_win) + 1) % NUM_REQ);
        w_oh        = '0;
        w_oh[w_win] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            gnt       <= '0;
            q         <= 1'b0;
            q_changed <= 1'b0;
            cmd_cnt   <= '0;
            busy      <= 1'b0;
`ifdef JK_ARB_LOCK_EN
            r_last    <= '0;
`endif
        end else begin
            busy      <= w_any;
            gnt       <= w_any ? w_oh : '0;
            q_changed <= w_any && (w_nxt_q != q);
            if (w_any) begin
                q       <= w_nxt_q;
                r_ptr   <= w_nxt_ptr;
                cmd_cnt <= &cmd_cnt ? cmd_cnt : cmd_cnt + 1'b1;
`ifdef JK_ARB_LOCK_EN
                r_last  <= w_win;
`endif
            end
        end
    end
endmodule

// File: tb/tb_jk_share_arbiter.sv
// tb_jk_share_arbiter: random and directed checks of jk_share_arbiter against a queue-free behavioural model.
module tb_jk_share_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] jk = '0;
    logic [3:0] gnt, s_gnt;
    logic       q, q_changed, busy, s_q, s_chg, s_busy;
    logic [7:0] cmd_cnt;
    logic [1:0] s_cnt;
    int         checks = 0;
    int         failures = 0;
    int         m_ptr, m_cnt, m_sat;
    logic       m_q, e_chg, e_busy;
    logic [3:0] e_gnt;
    logic       q_hold;
    logic [1:0] cmds [5] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
    logic       eq   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       ec   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    jk_share_arbiter #(.NUM_REQ(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .jk(jk),
        .gnt(gnt), .q(q), .q_changed(q_changed), .cmd_cnt(cmd_cnt), .busy(busy)
    );
    jk_share_arbiter #(.NUM_REQ(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .jk(jk),
        .gnt(s_gnt), .q(s_q), .q_changed(s_chg), .cmd_cnt(s_cnt), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_sat = 0; m_q = 1'b0;
        e_gnt = '0; e_chg = 1'b0; e_busy = 1'b0;
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("q", 32'(q), 32'(m_q));
        chk("q_changed", 32'(q_changed), 32'(e_chg));
        chk("cmd_cnt", 32'(cmd_cnt), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("sat_gnt", 32'(s_gnt), 32'(e_gnt));
        chk("sat_q", 32'(s_q), 32'(m_q));
        chk("sat_cnt", 32'(s_cnt), 32'(m_sat));
    endtask

    function automatic logic [7:0] rand_jk(input logic [3:0] r);
        logic [7:0] c;
        c = 8'($urandom);
        for (int i = 0; i < 4; i++) if (!r[i]) c[2*i +: 2] = 2'bxx;
        return c;
    endfunction

    // Drive at the negedge, let the edge happen, update the model, sample 1 time unit later.
    task automatic cycle(input logic [3:0] r, input logic [7:0] c);
        int         w;
        logic [1:0] cmd;
        logic       nq;
        req = r;
        jk  = c;
        @(posedge clk);
        e_busy = |r;
        if (r == 4'b0) begin
            e_gnt = '0;
            e_chg = 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++) if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            cmd = c[2*w +: 2];
            case (cmd)
                2'b00:   nq = m_q;
                2'b01:   nq = 1'b0;
                2'b10:   nq = 1'b1;
                default: nq = ~m_q;
            endcase
            e_chg = nq != m_q;
            m_q   = nq;
            m_cnt = m_cnt == 255 ? 255 : m_cnt + 1;
            m_sat = m_sat == 3 ? 3 : m_sat + 1;
            e_gnt = 4'(1 << w);
            m_ptr = (w + 1) % 4;
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] c;
        logic [3:0] r;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(4'hf, rand_jk(4'hf));
            chk("fair_gnt", 32'(gnt), 32'(1 << (i % 4)));
            chk("sat_seq", 32'(s_cnt), 32'(i < 3 ? i + 1 : 3));
        end
        chk("fair_cnt", 32'(cmd_cnt), 32'd8);
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom);
            cycle(r, rand_jk(r));
        end
        req = 4'hf;
        jk  = rand_jk(4'hf);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_cnt", 32'(cmd_cnt), 32'd0);
        chk("rst_chg", 32'(q_changed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'hf, 8'h00);
        chk("rst_first", 32'(gnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            c = 'x;
            c[5:4] = cmds[i];
            cycle(4'b0100, c);
            chk("cmd_q", 32'(q), 32'(eq[i]));
            chk("cmd_chg", 32'(q_changed), 32'(ec[i]));
        end
        cycle(4'b0100, rand_jk(4'b0100));
        chk("skip_g2", 32'(gnt), 32'h4);
        q_hold = q;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, 8'bx);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_q", 32'(q), 32'(q_hold));
        end
        cycle(4'b0101, rand_jk(4'b0101));
        chk("wrap_g0", 32'(gnt), 32'h1);
        cycle(4'b0101, rand_jk(4'b0101));
        chk("next_g2", 32'(gnt), 32'h4);
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            cycle(r, rand_jk(r));
        end
        chk("cnt_sat", 32'(cmd_cnt), 32'hff);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
